// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the ALU operation, resolves forwarded operands and
// registers them for execute. Optional counters are built with ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    Imm,
  input  logic                     ALUSrc,
  input  logic [1:0]               ForwardA,
  input  logic [1:0]               ForwardB,
  input  logic [DATA_WIDTH-1:0]    ExMemResult,
  input  logic [DATA_WIDTH-1:0]    WbResult,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [DATA_WIDTH-1:0]    StoreData,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  output logic                     illegal_op,
  output logic [31:0]              issue_count,
  output logic [31:0]              bubble_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BLT = 4'b1001;
  localparam logic [3:0] OP_BGE = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;
  localparam logic [3:0] OP_SLT = 4'b1100;

  logic [3:0]               dec_op;
  logic                     dec_illegal;
  logic                     f7_zero;
  logic                     f7_alt;
  logic [DATA_WIDTH-1:0]    fwd_a;
  logic [DATA_WIDTH-1:0]    fwd_b;
  logic [DATA_WIDTH-1:0]    src_b_mux;
  logic [DATA_WIDTH-1:0]    src_b_final;

  logic [DATA_WIDTH-1:0]    src_a_q, src_a_d;
  logic [DATA_WIDTH-1:0]    src_b_q, src_b_d;
  logic [DATA_WIDTH-1:0]    store_data_q, store_data_d;
  logic [OPCODE_LENGTH-1:0] operation_q, operation_d;
  logic                     out_valid_q, out_valid_d;
  logic                     illegal_op_q, illegal_op_d;

  assign f7_zero = (Funct7 == 7'b0000000);
  assign f7_alt  = (Funct7 == 7'b0100000);

  // ALUOp[0] distinguishes I-type from R-type: I-type has no SUB form.
  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        case (Funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: begin
        case (Funct3)
          3'b000: begin
            if (ALUOp[0] || f7_zero) dec_op = OP_ADD;
            else if (f7_alt)         dec_op = OP_SUB;
            else                     dec_illegal = 1'b1;
          end
          3'b001: begin dec_op = OP_SLL; dec_illegal = !f7_zero; end
          3'b010: begin dec_op = OP_SLT; dec_illegal = !f7_zero; end
          3'b011: dec_illegal = 1'b1;
          3'b100: begin dec_op = OP_XOR; dec_illegal = !f7_zero; end
          3'b101: begin
            if (f7_zero)     dec_op = OP_SRL;
            else if (f7_alt) dec_op = OP_SRA;
            else             dec_illegal = 1'b1;
          end
          3'b110: begin dec_op = OP_OR;  dec_illegal = !f7_zero; end
          default: begin dec_op = OP_AND; dec_illegal = !f7_zero; end
        endcase
      end
    endcase
  end

  // 11 falls back to the register value just like 00.
  always_comb begin
    case (ForwardA)
      2'b10:   fwd_a = ExMemResult;
      2'b01:   fwd_a = WbResult;
      default: fwd_a = RD1;
    endcase
    case (ForwardB)
      2'b10:   fwd_b = ExMemResult;
      2'b01:   fwd_b = WbResult;
      default: fwd_b = RD2;
    endcase
  end

  always_comb begin
    src_b_mux   = ALUSrc ? Imm : fwd_b;
    src_b_final = src_b_mux;
    if (dec_op == OP_SLL || dec_op == OP_SRL || dec_op == OP_SRA) begin
      src_b_final      = '0;
      src_b_final[4:0] = src_b_mux[4:0];
    end
  end

  always_comb begin
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    store_data_d = store_data_q;
    operation_d  = operation_q;
    out_valid_d  = out_valid_q;
    illegal_op_d = 1'b0;
    if (flush || (!stall && (!in_valid || dec_illegal))) begin
      src_a_d      = '0;
      src_b_d      = '0;
      store_data_d = '0;
      operation_d  = '0;
      out_valid_d  = 1'b0;
      illegal_op_d = !flush && in_valid && dec_illegal;
    end else if (!stall) begin
      src_a_d      = fwd_a;
      src_b_d      = src_b_final;
      store_data_d = fwd_b;
      operation_d  = OPCODE_LENGTH'(dec_op);
      out_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_a_q      <= '0;
      src_b_q      <= '0;
      store_data_q <= '0;
      operation_q  <= '0;
      out_valid_q  <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      store_data_q <= store_data_d;
      operation_q  <= operation_d;
      out_valid_q  <= out_valid_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign SrcA       = src_a_q;
  assign SrcB       = src_b_q;
  assign StoreData  = store_data_q;
  assign Operation  = operation_q;
  assign out_valid  = out_valid_q;
  assign illegal_op = illegal_op_q;

`ifdef ALU_ISSUE_PERF_EN
  logic        do_issue;
  logic        do_bubble;
  logic [31:0] issue_count_q, issue_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  // A stall without flush is neither an issue nor a bubble.
  assign do_issue  = !flush && !stall && in_valid && !dec_illegal;
  assign do_bubble = flush || (!stall && (!in_valid || dec_illegal));

  always_comb begin
    issue_count_d  = issue_count_q + {31'b0, do_issue};
    bubble_count_d = bubble_count_q + {31'b0, do_bubble};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      issue_count_q  <= issue_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign issue_count  = issue_count_q;
  assign bubble_count = bubble_count_q;
`else
  assign issue_count  = '0;
  assign bubble_count = '0;
`endif

endmodule
